// File: rtl/booth_pkg.sv
// Shared types for the radix-8 Booth multiplier stages.
package booth_pkg;

  typedef struct packed {
    logic [2:0] code;
    logic       sign;
  } t_enc_out;

endpackage

// File: rtl/booth_r8_accumulator.sv
// Sequential radix-8 Booth back-end: selects 0/X/2X/3X/4X per digit and
// accumulates the shifted signed partial products into the full product.
//
// state  | meaning
// IDLE   | waiting for start_i, previous result already taken
// PRE3X  | one cycle to register A3 = A + 2A
// ACCUM  | accepting Booth digits, one per handshake
// DONE   | product presented until res_ready_i
module booth_r8_accumulator
  import booth_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  output logic               busy_o,
  input  logic               dig_valid_i,
  input  t_enc_out           dig_i,
  output logic               dig_ready_o,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [2*WIDTH-1:0] res_o,
  output logic               err_o
);

  localparam int NDIG  = (WIDTH + 3) / 3;
  localparam int CNT_W = $clog2(NDIG + 1);
  localparam int PP_W  = WIDTH + 4;
  localparam int ACC_W = 2 * WIDTH + 4;
  localparam int SH_W  = $clog2(3 * NDIG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE3X = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } t_state;

  t_state             r_state;
  t_state             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH+1:0]   r_a3;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic               w_start;
  logic               w_hs;
  logic               w_last;
  logic               w_illegal;
  logic [PP_W-1:0]    w_mag;
  logic [PP_W-1:0]    w_pp;
  logic [ACC_W-1:0]   w_pp_ext;
  logic [SH_W-1:0]    w_shamt;
  logic [ACC_W-1:0]   w_pp_sh;
  logic               w_acc_top_unused;

  assign w_start = (r_state == S_IDLE) && start_i;
  assign w_hs    = (r_state == S_ACCUM) && dig_valid_i;
  assign w_last  = (r_cnt == CNT_W'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_PRE3X;
      S_PRE3X: w_state_nxt = S_ACCUM;
      S_ACCUM: if (dig_valid_i && w_last) w_state_nxt = S_DONE;
      S_DONE:  if (res_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Illegal codes 101/110/111 contribute nothing but are flagged.
  always_comb begin
    w_mag     = '0;
    w_illegal = 1'b0;
    case (dig_i.code)
      3'd0:    w_mag = '0;
      3'd1:    w_mag = PP_W'(r_a);
      3'd2:    w_mag = PP_W'({r_a, 1'b0});
      3'd3:    w_mag = PP_W'(r_a3);
      3'd4:    w_mag = PP_W'({r_a, 2'b00});
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_pp     = dig_i.sign ? (~w_mag + PP_W'(1)) : w_mag;
  assign w_pp_ext = {{(ACC_W - PP_W){w_pp[PP_W-1]}}, w_pp};
  assign w_shamt  = SH_W'(3 * r_cnt);
  assign w_pp_sh  = w_pp_ext << w_shamt;

  // Two's-complement accumulator held as raw bits; the headroom bits only
  // carry the sign of negative intermediates and never reach res_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_a3  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_a   <= a_i;
        r_acc <= '0;
        r_cnt <= '0;
        r_err <= 1'b0;
      end
      if (r_state == S_PRE3X) begin
        r_a3 <= {2'b00, r_a} + {1'b0, r_a, 1'b0};
      end
      if (w_hs) begin
        r_acc <= r_acc + w_pp_sh;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_illegal) r_err <= 1'b1;
      end
    end
  end

  assign w_acc_top_unused = ^r_acc[ACC_W-1:2*WIDTH];

  assign busy_o      = (r_state != S_IDLE);
  assign dig_ready_o = (r_state == S_ACCUM);
  assign res_valid_o = (r_state == S_DONE);
  assign res_o       = r_acc[2*WIDTH-1:0];
  assign err_o       = r_err;

endmodule

// File: tb/tb_booth_r8_accumulator.sv
// Scoreboard bench for booth_r8_accumulator: randomized operands, Booth
// digits derived from the multiplier, expected products from plain arithmetic.
module tb_booth_r8_accumulator;
  import booth_pkg::*;

  localparam int W    = 24;
  localparam int NDIG = (W + 3) / 3;

  typedef t_enc_out t_digs [NDIG];
  typedef struct {
    logic [2*W-1:0] res;
    logic           err;
  } t_exp;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_i;
  logic [W-1:0]   a_i;
  logic           busy_o;
  logic           dig_valid_i;
  t_enc_out       dig_i;
  logic           dig_ready_o;
  logic           res_valid_o;
  logic           res_ready_i;
  logic [2*W-1:0] res_o;
  logic           err_o;

  booth_r8_accumulator #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .a_i(a_i), .busy_o(busy_o),
    .dig_valid_i(dig_valid_i), .dig_i(dig_i), .dig_ready_o(dig_ready_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_o(res_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk  = 0;
  int   n_pass = 0;
  t_exp sb_q[$];

  task automatic check(input string name, input longint unsigned got,
                       input longint unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  always @(negedge clk) begin
    t_exp e;
    if (rst_n && res_valid_o && res_ready_i) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL monitor: result 0x%0h with empty scoreboard", res_o);
      end else begin
        e = sb_q.pop_front();
        check("res", res_o, e.res);
        check("err", err_o, e.err);
      end
    end
  end

  // Radix-8 Booth recoding of an unsigned multiplier: v = -4b2 + 2b1 + b0 + b_-1.
  function automatic t_digs encode(input logic [W-1:0] b);
    t_digs d;
    logic [3*NDIG:0] x;
    int v;
    x = '0;
    x[W:1] = b;
    for (int i = 0; i < NDIG; i++) begin
      v = -4 * int'(x[3*i+3]) + 2 * int'(x[3*i+2]) + int'(x[3*i+1]) + int'(x[3*i]);
      d[i].sign = (v < 0);
      d[i].code = 3'(v < 0 ? -v : v);
    end
    return d;
  endfunction

  function automatic t_exp digit_sum(input logic [W-1:0] a, input t_digs d);
    t_exp   e;
    longint s;
    longint m;
    s = 0;
    e.err = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (d[i].code <= 3'd4) m = longint'(d[i].code);
      else begin
        m = 0;
        e.err = 1'b1;
      end
      if (d[i].sign) m = -m;
      s += m * longint'(a) * (longint'(1) << (3 * i));
    end
    e.res = s[2*W-1:0];
    return e;
  endfunction

  function automatic t_exp product(input logic [W-1:0] a, input logic [W-1:0] b);
    t_exp   e;
    longint p;
    p = longint'(a) * longint'(b);
    e.res = p[2*W-1:0];
    e.err = 1'b0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input t_digs d,
                        input t_exp e, input logic [3:0] pat, input int stall);
    int e0, idx, gaps, step, guard;
    logic rdy, v;
    t_enc_out extra;
    extra.code = 3'd1;
    extra.sign = 1'b0;
    sb_q.push_back(e);
    res_ready_i = (stall == 0);
    tick();
    start_i = 1'b1;
    a_i = a;
    tick();
    start_i = 1'b0;
    a_i = W'($urandom);
    e0 = cyc;
    idx = 0; gaps = 0; step = 0; guard = 0;
    while (!res_valid_o && guard < 400) begin
      rdy = dig_ready_o;
      if (!rdy) v = 1'b1;
      else begin
        v = pat[step % 4];
        step++;
      end
      dig_valid_i = v;
      dig_i = (idx < NDIG) ? d[idx] : extra;
      if (v && rdy) idx++;
      else if (rdy) gaps++;
      tick();
      guard++;
    end
    if (!res_valid_o) begin
      check({tag, "_timeout"}, res_valid_o, 1);
      sb_q.delete();
      return;
    end
    check({tag, "_latency"}, cyc - e0, NDIG + 1 + gaps);
    check({tag, "_handshakes"}, idx, NDIG);
    dig_valid_i = 1'b1;
    dig_i = extra;
    for (int k = 0; k < stall; k++) begin
      check({tag, "_hold_res"}, res_o, e.res);
      check({tag, "_hold_err"}, err_o, e.err);
      check({tag, "_hold_ready"}, dig_ready_o, 0);
      check({tag, "_hold_valid"}, res_valid_o, 1);
      start_i = (k == 1);
      tick();
    end
    start_i = 1'b0;
    res_ready_i = 1'b1;
    tick();
    dig_valid_i = 1'b0;
    check({tag, "_busy_after"}, busy_o, 0);
    check({tag, "_valid_after"}, res_valid_o, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_dig_ready"}, dig_ready_o, 0);
    check({tag, "_res_valid"}, res_valid_o, 0);
    check({tag, "_res"}, res_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  t_digs d35, dz, dill, d;
  t_exp  e35, e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    int pos;
    rst_n = 1'b0;
    start_i = 1'b0;
    a_i = '0;
    dig_valid_i = 1'b0;
    dig_i = '0;
    res_ready_i = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      dz[i] = '0;
    end
    d35 = dz;
    d35[0].code = 3'd1; d35[0].sign = 1'b1;
    d35[1].code = 3'd1; d35[1].sign = 1'b0;
    e35.res = 48'd35;
    e35.err = 1'b0;
    #12;
    check_zero_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    run_op("basic35", 24'd5, d35, e35, 4'b1111, 0);
    run_op("allones", 24'hFFFFFF, encode(24'hFFFFFF), product(24'hFFFFFF, 24'hFFFFFF), 4'b1111, 0);
    b = W'($urandom);
    run_op("a_zero", 24'd0, encode(b), product(24'd0, b), 4'b1111, 1);
    run_op("gaps1001", 24'd5, d35, e35, 4'b1001, 0);

    dill = dz;
    dill[3].code = 3'b101;
    e.res = '0;
    e.err = 1'b1;
    run_op("illegal", 24'd1, dill, e, 4'b1111, 0);
    run_op("after_illegal", 24'd5, d35, e35, 4'b1111, 0);
    run_op("stall5", 24'd5, d35, e35, 4'b1111, 5);

    // Abort mid-operation: four digits in, including an illegal one.
    d = d35;
    d[2].code = 3'b110;
    tick();
    start_i = 1'b1;
    a_i = 24'd5;
    tick();
    start_i = 1'b0;
    pos = 0;
    for (int g = 0; g < 50 && pos < 4; g++) begin
      dig_valid_i = 1'b1;
      dig_i = d[pos];
      if (dig_ready_o) pos++;
      tick();
    end
    check("abort_digits_taken", pos, 4);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    dig_valid_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    run_op("post_reset35", 24'd5, d35, e35, 4'b1111, 0);

    for (int n = 0; n < 20; n++) begin
      a = W'($urandom);
      b = W'($urandom);
      run_op("rand", a, encode(b), product(a, b), 4'($urandom) | 4'b0001,
             int'($urandom_range(0, 3)));
    end
    for (int n = 0; n < 5; n++) begin
      a = W'($urandom);
      d = encode(W'($urandom));
      pos = int'($urandom_range(0, NDIG - 1));
      d[pos].code = 3'($urandom_range(5, 7));
      run_op("rand_illegal", a, d, digit_sum(a, d), 4'b1111, int'($urandom_range(0, 2)));
    end

    tick();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
